// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control chain: the RV32I control bundle,
// its packed width, the bubble word and pack/unpack helpers.
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wd_src;
        logic       mem_write;
        logic [2:0] funct3;
        logic       branch;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_bundle_t b);
        return b;
    endfunction

    function automatic ctrl_bundle_t ctrl_unpack(input logic [CTRL_W-1:0] w);
        return ctrl_bundle_t'(w);
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One valid+control register of the chain. Next-state priority:
// reset > flush > stall (hold) > upstream holding (bubble) > load from upstream.
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int W = CTRL_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_valid,
    input  logic [W-1:0] up_ctrl,
    input  logic         up_hold,
    input  logic         flush,
    input  logic         stall,
    output logic         valid_q,
    output logic [W-1:0] ctrl_q
);

    logic         valid_d;
    logic [W-1:0] ctrl_d;

    always_comb begin
        // NOTE: defaults first so every branch assigns both signals; no latch is inferred.
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = W'(CTRL_BUBBLE);
        end else if (stall) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (up_hold) begin
            // Upstream is frozen: taking its word now would duplicate it.
            valid_d = 1'b0;
            ctrl_d  = W'(CTRL_BUBBLE);
        end else begin
            valid_d = up_valid;
            ctrl_d  = up_valid ? up_ctrl : W'(CTRL_BUBBLE);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Parametrised chain of pipeline control registers with per-stage stall/flush,
// automatic bubble insertion behind a stall and a saturating bubble counter.
module pipe_ctrl_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int W       = CTRL_W,
    parameter int NSTAGES = 3,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_ctrl,
    input  logic [NSTAGES-1:0]   stall,
    input  logic [NSTAGES-1:0]   flush,
    output logic [NSTAGES-1:0]   stage_valid,
    output logic [NSTAGES*W-1:0] stage_ctrl,
    output logic                 out_valid,
    output logic [W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        logic         up_valid;
        logic [W-1:0] up_ctrl;
        logic         up_hold;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_ctrl  = in_ctrl;
            assign up_hold  = 1'b0;
        end else begin : g_tail
            assign up_valid = stage_valid[k-1];
            assign up_ctrl  = stage_ctrl[(k-1)*W +: W];
            assign up_hold  = stall[k-1];
        end

        pipe_ctrl_stage #(.W(W)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_valid),
            .up_ctrl  (up_ctrl),
            .up_hold  (up_hold),
            .flush    (flush[k]),
            .stall    (stall[k]),
            .valid_q  (stage_valid[k]),
            .ctrl_q   (stage_ctrl[k*W +: W])
        );
    end

    assign out_valid = stage_valid[NSTAGES-1];
    assign out_ctrl  = stage_ctrl[(NSTAGES-1)*W +: W];

    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule
